rr_arbiter4: RTL and testbench
==============================

// Module: rr_arbiter4
// PURPOSE
//  Four-requester round-robin arbiter sharing one resource (bus/port) between agents.
//  Encodes the winner as a 2-bit index, then decodes it to a one-hot grant vector
//  with an enable, the same address/enable-to-one-hot function as the 2-to-4 decoder.
//  Adds a hold timeout and a one-cycle turnaround gap between owners.
// PARAMETERS
//  MAX_HOLD  16  max consecutive GRANT cycles per owner; 0 = no timeout
//  CNT_W     5   hold-counter width; must hold MAX_HOLD (>= clog2(MAX_HOLD+1))
// PORTS
//  clk        in   1  single clock, all state on rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  en         in   1  arbitration enable; 0 blocks new grants only
//  req        in   4  request per agent, level, held until served
//  done       in   1  current owner finished; sampled only in GRANT
//  grant      out  4  one-hot grant, registered; all 0 outside GRANT
//  grant_idx  out  2  index of current/last owner
//  busy       out  1  1 while in GRANT
//  timeout    out  1  one-cycle pulse, grant revoked by hold limit
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, ptr=0, grant=4'b0000, grant_idx=0,
//   busy=0, timeout=0, hold count=0. Any mid-grant reset drops grant immediately.
//  States: IDLE, GRANT, GAP. All outputs registered; no comb path req->grant.
//  Selection: the first asserted req scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//  IDLE: if en && |req: select winner -> GRANT; grant_idx=winner;
//   grant=1<<winner; busy=1; count=1. Else stay IDLE.
//   Latency: req high at edge N -> grant high after edge N (1 cycle).
//  GRANT: leaves on the first edge where any of the following holds:
//   a) done=1;
//   b) req[grant_idx]=0, meaning the owner withdrew;
//   c) MAX_HOLD!=0 && count==MAX_HOLD, which is a timeout.
//   On leaving: -> GAP; grant=0; busy=0; ptr=grant_idx+1 (wraps 3->0);
//   timeout=1 only for case c with done=0 and req[idx]=1 (done wins ties).
//   While staying: count++ (saturates, never wraps); grant stays stable.
//   en has no effect in GRANT.
//  GAP: exactly one cycle with grant=0; timeout clears after it.
//   In GAP, arbitration runs as in IDLE: winner -> GRANT, else -> IDLE.
//   Back-to-back owners are therefore separated by exactly one grant-low cycle.
//  Fairness: a continuously requesting agent waits at most 3 tenures.
//  grant_idx keeps the last owner in IDLE/GAP; ptr is not a port.
//  Invariants: $onehot0(grant) always; grant!=0 iff busy;
//   grant==1<<grant_idx whenever busy.
//  req changes on non-owner lines during GRANT are ignored until GAP.
// TESTING
//  1 reset: reset_n=0 mid-GRANT -> grant=0000, busy=0 at once; after release
//    req=0001 -> grant=0001 one cycle later.
//  2 rotation: req=1111 held, done pulsed each tenure -> grants 0001,0010,
//    0100,1000,0001, each separated by one grant=0000 cycle.
//  3 priority wrap: finish agent 2 (ptr=3), then req=0101 -> grant=0001;
//    with req=1101 instead -> grant=1000.
//  4 timeout: MAX_HOLD=4, req=0010 held, done=0 -> grant=0010 for 4 cycles,
//    then timeout=1 for 1 cycle, grant=0000; the same agent is regranted after GAP.
//  5 tie: done=1 on the MAX_HOLD cycle -> release with timeout=0; owner drops
//    req -> release next edge, ptr advances.
//  6 enable: en=0 with req=1111 -> grant stays 0000; en=0 during GRANT
//    -> tenure continues; en=1 -> grant within 1 cycle.

Source files
------------

// File: rtl/rr_arbiter4_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter4_if
//  Description : Request/grant bundle between four agents and the
//                round-robin arbiter. The arbiter side drives the grant
//                outputs; the agent side drives requests, enable and done.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_arbiter4_if;
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       timeout;

    modport master (
        input  en,
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output busy,
        output timeout
    );

    modport slave (
        output en,
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  busy,
        input  timeout
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter4
//  Description : Four-requester round-robin arbiter with a per-owner hold
//                timeout and a one-cycle grant-low gap between owners.
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4 #(
    parameter int MAX_HOLD = 16,   // 0 disables the hold timeout
    parameter int CNT_W    = 5     // must be able to hold MAX_HOLD
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    rr_arbiter4_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit               HOLD_EN    = (MAX_HOLD != 0);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [3:0]       req_rot;
    logic [1:0]       win_off;
    logic [1:0]       winner;
    logic             any_req;
    logic             owner_req;
    logic             hold_hit;
    logic             release_now;

    // Rotate requests so bit 0 is the agent at ptr, then pick the first set bit.
    always_comb begin
        case (ptr_q)
            2'd0:    req_rot = bus.req;
            2'd1:    req_rot = {bus.req[0],   bus.req[3:1]};
            2'd2:    req_rot = {bus.req[1:0], bus.req[3:2]};
            default: req_rot = {bus.req[2:0], bus.req[3]};
        endcase
        if (req_rot[0])      win_off = 2'd0;
        else if (req_rot[1]) win_off = 2'd1;
        else if (req_rot[2]) win_off = 2'd2;
        else                 win_off = 2'd3;
        winner  = ptr_q + win_off;
        any_req = |bus.req;
    end

    // Release conditions for the current owner; done takes priority over timeout.
    always_comb begin
        owner_req   = bus.req[idx_q];
        hold_hit    = HOLD_EN && (count_q == HOLD_LIMIT);
        release_now = bus.done || !owner_req || hold_hit;
    end

    // Next-state and next-output logic; IDLE and GAP arbitrate identically.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        count_d   = count_q;
        case (state_q)
            IDLE, GAP: begin
                if (bus.en && any_req) begin
                    state_d = GRANT;
                    idx_d   = winner;
                    grant_d = 4'b0001 << winner;
                    busy_d  = 1'b1;
                    count_d = CNT_ONE;
                end else begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d   = GAP;
                    grant_d   = 4'b0000;
                    busy_d    = 1'b0;
                    ptr_d     = idx_q + 2'd1;
                    timeout_d = hold_hit && !bus.done && owner_req;
                    count_d   = '0;
                end else if (count_q != CNT_SAT) begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            grant_q   <= 4'b0000;
            idx_q     <= 2'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.busy      = busy_q;
    assign bus.timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter4
//  Description : Directed bench for rr_arbiter4 (MAX_HOLD=4) covering reset,
//                rotation, pointer wrap, timeout, done/timeout tie and enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    rr_arbiter4_if bus ();

    rr_arbiter4 #(
        .MAX_HOLD (4),
        .CNT_W    (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n  = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        bus.en   = 1'b1;
        tick;
        tick;
        reset_n  = 1'b1;
    endtask

    // Structural invariants sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            check("inv_onehot0", {3'b000, $onehot0(bus.grant)}, 4'b0001);
            check("inv_busy", {3'b000, (bus.grant != 4'b0000)}, {3'b000, bus.busy});
            if (bus.busy)
                check("inv_idx", bus.grant, 4'b0001 << bus.grant_idx);
        end
    end

    logic [3:0] rot_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] idx_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        reset_n  = 1'b0;
        bus.en   = 1'b1;
        bus.req  = 4'b0000;
        bus.done = 1'b0;

        // 1: reset state, first grant latency, asynchronous mid-grant reset
        do_reset;
        check("rst_grant", bus.grant, 4'b0000);
        check("rst_idx", {2'b00, bus.grant_idx}, 4'd0);
        check("rst_busy", {3'b000, bus.busy}, 4'd0);
        check("rst_timeout", {3'b000, bus.timeout}, 4'd0);
        bus.req = 4'b0001;
        tick;
        check("t1_grant", bus.grant, 4'b0001);
        check("t1_busy", {3'b000, bus.busy}, 4'd1);
        tick;
        reset_n = 1'b0;
        #1;
        check("t1_async_grant", bus.grant, 4'b0000);
        check("t1_async_busy", {3'b000, bus.busy}, 4'd0);
        #1;
        reset_n = 1'b1;
        tick;
        check("t1_regrant", bus.grant, 4'b0001);

        // 2: rotation with all requesting, done each tenure
        do_reset;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick;
            check("t2_grant", bus.grant, rot_exp[k]);
            check("t2_idx", {2'b00, bus.grant_idx}, {2'b00, idx_exp[k]});
            if (k < 4) begin
                bus.done = 1'b1;
                tick;
                check("t2_gap", bus.grant, 4'b0000);
                bus.done = 1'b0;
            end
        end

        // 3: pointer wrap after agent 2
        do_reset;
        bus.req = 4'b0100;
        tick;
        check("t3_own2", bus.grant, 4'b0100);
        bus.req = 4'b0000;
        tick;
        tick;
        bus.req = 4'b0101;
        tick;
        check("t3_wrap0", bus.grant, 4'b0001);
        do_reset;
        bus.req = 4'b0100;
        tick;
        bus.req = 4'b0000;
        tick;
        tick;
        bus.req = 4'b1101;
        tick;
        check("t3_wrap3", bus.grant, 4'b1000);

        // 4: hold timeout at 4 cycles, then regrant of the same agent
        do_reset;
        bus.req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            tick;
            check("t4_hold", bus.grant, 4'b0010);
            check("t4_no_to", {3'b000, bus.timeout}, 4'd0);
        end
        tick;
        check("t4_to_grant", bus.grant, 4'b0000);
        check("t4_to_pulse", {3'b000, bus.timeout}, 4'd1);
        check("t4_to_busy", {3'b000, bus.busy}, 4'd0);
        tick;
        check("t4_regrant", bus.grant, 4'b0010);
        check("t4_to_clear", {3'b000, bus.timeout}, 4'd0);

        // 5: done on the limit cycle wins over timeout; withdraw releases
        tick;
        tick;
        tick;
        check("t5_hold4", bus.grant, 4'b0010);
        bus.done = 1'b1;
        tick;
        check("t5_tie_grant", bus.grant, 4'b0000);
        check("t5_tie_to", {3'b000, bus.timeout}, 4'd0);
        bus.done = 1'b0;
        tick;
        check("t5_regrant", bus.grant, 4'b0010);
        bus.req = 4'b1001;
        tick;
        check("t5_withdraw", bus.grant, 4'b0000);
        check("t5_wd_to", {3'b000, bus.timeout}, 4'd0);
        tick;
        check("t5_next", bus.grant, 4'b1000);

        // 6: enable gates new grants only
        do_reset;
        bus.en  = 1'b0;
        bus.req = 4'b1111;
        tick;
        tick;
        check("t6_blocked", bus.grant, 4'b0000);
        check("t6_blk_busy", {3'b000, bus.busy}, 4'd0);
        bus.en = 1'b1;
        tick;
        check("t6_enable", bus.grant, 4'b0001);
        bus.en = 1'b0;
        tick;
        check("t6_keep", bus.grant, 4'b0001);
        bus.done = 1'b1;
        tick;
        check("t6_rel", bus.grant, 4'b0000);
        bus.done = 1'b0;
        tick;
        check("t6_idle", bus.grant, 4'b0000);
        bus.en = 1'b1;
        tick;
        check("t6_next", bus.grant, 4'b0010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
